// File: rtl/otp_cipher_core.sv
// otp_cipher_core: one-time-pad encrypt/decrypt with an LFSR pad source and a burn-after-use pad store.
module otp_cipher_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_err,
    output logic [IDX_W:0]    pad_count
);
    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0]  wr_ptr;
    logic [DEPTH-1:0]  live;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pad;
    logic              fire, enc_ok, dec_ok;
    assign in_ready = ena & (~out_valid | out_ready);
    assign fire = in_valid & in_ready;
    assign pad = lfsr[DATA_W-1:0];
    assign enc_ok = fire & ~in_mode & ~live[wr_ptr];
    assign dec_ok = fire & in_mode & live[in_index];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
            wr_ptr <= '0;
            live <= '0;
            pad_count <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_index <= '0;
            out_err <= 1'b0;
        end else begin
            if (fire) begin
                out_valid <= 1'b1;
                out_index <= in_mode ? in_index : wr_ptr;
                out_err <= ~(enc_ok | dec_ok);
                out_data <= enc_ok ? in_data ^ pad : dec_ok ? in_data ^ mem[in_index] : '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (enc_ok) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
                lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
                pad_count <= pad_count + 1'b1;
            end
            if (dec_ok) begin
                live[in_index] <= 1'b0;
                pad_count <= pad_count - 1'b1;
            end
        end
    end
    // Pad storage needs no reset: a slot is only read while its live bit is set.
    always_ff @(posedge clk) begin
        if (rst_n && enc_ok) mem[wr_ptr] <= pad;
    end
endmodule
